// File: rtl/bnn_xnor_layer.sv
// bnn_xnor_layer: streaming binary-neuron layer, XNOR-popcount per chunk,
// per-neuron accumulate, threshold compare at the last chunk of each vector.
module bnn_xnor_layer #(
    parameter int CHUNK   = 8,
    parameter int NCHUNK  = 8,
    parameter int NEURONS = 8,
    localparam int VW     = CHUNK * NCHUNK,
    localparam int NW     = NEURONS * NCHUNK,
    localparam int ACC_W  = ($clog2(VW + 1) < 1) ? 1 : $clog2(VW + 1),
    localparam int CA_W   = ($clog2(NW) < 1) ? 1 : $clog2(NW),
    localparam int TA_W   = ($clog2(NEURONS) < 1) ? 1 : $clog2(NEURONS),
    localparam int KW     = ($clog2(NCHUNK) < 1) ? 1 : $clog2(NCHUNK)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_cfg_we,
    input  logic [CA_W-1:0]    i_cfg_addr,
    input  logic [CHUNK-1:0]   i_cfg_wdata,
    input  logic               i_thr_we,
    input  logic [TA_W-1:0]    i_thr_addr,
    input  logic [ACC_W-1:0]   i_thr_wdata,
    output logic               o_cfg_err,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [CHUNK-1:0]   i_in_data,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [NEURONS-1:0] o_out_data
);
    logic [CHUNK-1:0]   r_w   [NW];
    logic [ACC_W-1:0]   r_thr [NEURONS];
    logic [ACC_W-1:0]   r_acc [NEURONS];
    logic [KW-1:0]      r_k;
    logic               r_out_valid;
    logic [NEURONS-1:0] r_out_data;
    logic               r_cfg_err;
    logic [CHUNK-1:0]   w_match [NEURONS];
    logic [ACC_W-1:0]   w_sum   [NEURONS];
    logic               w_xfer;
    logic               w_last;
    logic               w_wr_any;
    logic               w_wr_bad;
    logic               w_wr_ok;

    assign o_in_ready  = !r_out_valid && !rst;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_cfg_err   = r_cfg_err;

    assign w_xfer   = i_in_valid && o_in_ready;
    assign w_last   = r_k == KW'(NCHUNK - 1);
    assign w_wr_any = i_cfg_we || i_thr_we;
    // A bad address on either strobe rejects both, so paired writes stay atomic.
    assign w_wr_bad = (i_cfg_we && {1'b0, i_cfg_addr} >= (CA_W + 1)'(NW)) ||
                      (i_thr_we && {1'b0, i_thr_addr} >= (TA_W + 1)'(NEURONS));
    assign w_wr_ok  = w_wr_any && !w_wr_bad && r_k == '0 && !r_out_valid && !w_xfer;

    always_comb begin
        for (int n = 0; n < NEURONS; n++) begin
            w_match[n] = ~(i_in_data ^ r_w[CA_W'(n * NCHUNK) + CA_W'(r_k)]);
            w_sum[n]   = r_acc[n];
            for (int b = 0; b < CHUNK; b++)
                w_sum[n] = w_sum[n] + ACC_W'(w_match[n][b]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_cfg_err   <= 1'b0;
            for (int n = 0; n < NEURONS; n++) begin
                r_acc[n] <= '0;
                r_thr[n] <= ACC_W'(VW / 2);
            end
            for (int a = 0; a < NW; a++)
                r_w[a] <= '0;
        end else begin
            r_cfg_err <= w_wr_any && !w_wr_ok;
            if (w_wr_ok && i_cfg_we)
                r_w[i_cfg_addr] <= i_cfg_wdata;
            if (w_wr_ok && i_thr_we)
                r_thr[i_thr_addr] <= i_thr_wdata;
            if (r_out_valid && i_out_ready)
                r_out_valid <= 1'b0;
            if (w_xfer) begin
                r_k <= w_last ? '0 : r_k + KW'(1);
                for (int n = 0; n < NEURONS; n++)
                    r_acc[n] <= w_last ? '0 : w_sum[n];
                if (w_last) begin
                    r_out_valid <= 1'b1;
                    for (int n = 0; n < NEURONS; n++)
                        r_out_data[n] <= w_sum[n] >= r_thr[n];
                end
            end
        end
    end
endmodule

// File: tb/tb_bnn_xnor_layer.sv
// tb_bnn_xnor_layer: directed and randomized checks of bnn_xnor_layer
// against a popcount reference model (CHUNK=8, NCHUNK=2, NEURONS=2).
module tb_bnn_xnor_layer;
    localparam int CHUNK = 8, NCHUNK = 2, NEURONS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_cfg_we = 1'b0;
    logic [1:0] i_cfg_addr = '0;
    logic [7:0] i_cfg_wdata = '0;
    logic       i_thr_we = 1'b0;
    logic       i_thr_addr = 1'b0;
    logic [4:0] i_thr_wdata = '0;
    logic       o_cfg_err;
    logic       i_in_valid = 1'b0;
    logic       o_in_ready;
    logic [7:0] i_in_data = '0;
    logic       o_out_valid;
    logic       i_out_ready = 1'b0;
    logic [1:0] o_out_data;

    int errs = 0;
    int checks = 0;
    logic [7:0] mw [2][2];
    logic [4:0] mthr [2];

    bnn_xnor_layer #(.CHUNK(CHUNK), .NCHUNK(NCHUNK), .NEURONS(NEURONS)) dut (
        .clk(clk), .rst(rst),
        .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_wdata(i_cfg_wdata),
        .i_thr_we(i_thr_we), .i_thr_addr(i_thr_addr), .i_thr_wdata(i_thr_wdata),
        .o_cfg_err(o_cfg_err),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: neuron fires when matching bits over the whole vector reach its threshold.
    function automatic logic [1:0] model(input logic [7:0] d0, input logic [7:0] d1);
        logic [1:0] r;
        for (int n = 0; n < 2; n++) begin
            int s;
            s = $countones(~(d0 ^ mw[n][0])) + $countones(~(d1 ^ mw[n][1]));
            r[n] = s >= int'(mthr[n]);
        end
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; i_in_valid = 1'b0; i_cfg_we = 1'b0; i_thr_we = 1'b0; i_out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", o_in_ready, 0);
        check("rst_out_valid", o_out_valid, 0);
        check("rst_out_data", o_out_data, 0);
        check("rst_cfg_err", o_cfg_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < 2; n++) begin
            mw[n][0] = 8'h00; mw[n][1] = 8'h00; mthr[n] = 5'd8;
        end
        @(negedge clk);
        check("post_rst_in_ready", o_in_ready, 1);
    endtask

    task automatic send(input logic [7:0] d);
        int t;
        t = 0;
        i_in_valid = 1'b1;
        i_in_data = d;
        while (!o_in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("send_ready", o_in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        i_in_valid = 1'b0;
    endtask

    task automatic expect_out(input logic [1:0] exp, input int hold, input string tag);
        check({tag, "_valid"}, o_out_valid, 1);
        check({tag, "_data"}, o_out_data, exp);
        check({tag, "_in_ready_lo"}, o_in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, o_out_valid, 1);
            check({tag, "_hold_data"}, o_out_data, exp);
            check({tag, "_hold_ready"}, o_in_ready, 0);
        end
        i_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_out_ready = 1'b0;
        check({tag, "_valid_clr"}, o_out_valid, 0);
        check({tag, "_in_ready_hi"}, o_in_ready, 1);
    endtask

    task automatic vec(input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] exp,
                       input int hold, input string tag);
        send(d0);
        check({tag, "_mid_valid"}, o_out_valid, 0);
        send(d1);
        expect_out(exp, hold, tag);
    endtask

    task automatic wr(input logic cw, input logic [1:0] ca, input logic [7:0] cd,
                      input logic tw, input logic ta, input logic [4:0] td,
                      input logic exp_err, input string tag);
        i_cfg_we = cw; i_cfg_addr = ca; i_cfg_wdata = cd;
        i_thr_we = tw; i_thr_addr = ta; i_thr_wdata = td;
        @(posedge clk);
        @(negedge clk);
        i_cfg_we = 1'b0; i_thr_we = 1'b0;
        check({tag, "_err"}, o_cfg_err, exp_err);
        if (!exp_err && cw) mw[ca[1]][ca[0]] = cd;
        if (!exp_err && tw) mthr[ta] = td;
        @(negedge clk);
        check({tag, "_err_clr"}, o_cfg_err, 0);
    endtask

    initial begin
        logic [7:0] d0, d1;
        do_reset();
        vec(8'h00, 8'h00, 2'b11, 0, "zeros");
        vec(8'hFF, 8'hFF, 2'b00, 0, "ones");
        wr(1'b1, 2'd2, 8'hFF, 1'b0, 1'b0, 5'd0, 1'b0, "w10");
        wr(1'b1, 2'd3, 8'hFF, 1'b1, 1'b1, 5'd16, 1'b0, "w11_thr1");
        vec(8'hFF, 8'hFF, 2'b10, 0, "n1_fire");
        vec(8'h0F, 8'hFF, 2'b00, 0, "n1_below");
        vec(8'h00, 8'h00, 2'b01, 5, "hold");
        vec(8'hFF, 8'hFF, 2'b10, 0, "back2back");
        do_reset();
        send(8'h55);
        wr(1'b1, 2'd0, 8'hAA, 1'b0, 1'b0, 5'd0, 1'b1, "busy_cfg");
        send(8'hF0);
        wr(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, "busy_thr");
        expect_out(2'b11, 0, "w00_kept");
        i_in_valid = 1'b1; i_in_data = 8'h55;
        i_cfg_we = 1'b1; i_cfg_addr = 2'd0; i_cfg_wdata = 8'hAA;
        @(posedge clk);
        @(negedge clk);
        i_in_valid = 1'b0; i_cfg_we = 1'b0;
        check("xfer_cfg_err", o_cfg_err, 1);
        send(8'hF0);
        expect_out(2'b11, 0, "xfer_w00_kept");
        send(8'hFF);
        do_reset();
        vec(8'h00, 8'h00, 2'b11, 0, "after_abort");
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 1) == 1)
                wr(1'($urandom), 2'($urandom), 8'($urandom), 1'b1, 1'($urandom),
                   5'($urandom_range(0, 20)), 1'b0, "rnd_wr");
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            send(d0);
            if ($urandom_range(0, 3) == 0)
                wr(1'b1, 2'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                   5'($urandom), 1'b1, "rnd_busy");
            send(d1);
            expect_out(model(d0, d1), int'($urandom_range(0, 3)), "rnd");
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
